// File: rtl/four_bank_mem.sv
// rtl/four_bank_mem.sv - word-interleaved four-bank memory with per-bank busy counters.
// Optional macro MEM_ALIGN_CHECK_EN: odd byte addresses are rejected and flag err.
module four_bank_mem #(
  parameter int MEM_WORDS = 8192,
  parameter int BANK_LAT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        wr,
  input  logic        rd,
  output logic [15:0] data_out,
  output logic [3:0]  busy,
  output logic        stall,
  output logic        err
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [15:0]      mem [MEM_WORDS];
  logic [3:0]       cnt [4];
  logic [1:0]       bank;
  logic [IDX_W-1:0] idx;
  logic             req_valid;
  logic             misalign;
  logic             err_set;
  logic             accept;
  logic             err_q;
  logic             rd_v1, rd_v2;
  logic [15:0]      rd_d1, rd_d2;

  // word index = {row mod (MEM_WORDS/4), bank}; higher address bits wrap silently
  assign bank      = addr[2:1];
  assign idx       = addr[IDX_W:1];
  assign req_valid = rd ^ wr;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = req_valid & addr[0];
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    busy = 4'b0000;
    for (int i = 0; i < 4; i++) busy[i] = (cnt[i] != 4'd0);
  end

  assign err_set  = (rd & wr) | misalign;
  assign stall    = req_valid & busy[bank] & ~misalign;
  assign accept   = req_valid & ~busy[bank] & ~err_set;
  assign err      = err_q;
  assign data_out = rd_v2 ? rd_d2 : 16'h0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) cnt[i] <= 4'd0;
      rd_v1 <= 1'b0;
      rd_v2 <= 1'b0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept && bank == 2'(i)) cnt[i] <= 4'(BANK_LAT - 1);
        else if (cnt[i] != 4'd0)     cnt[i] <= cnt[i] - 4'd1;
      end
      rd_v1 <= accept & rd;
      rd_v2 <= rd_v1;
      err_q <= err_q | err_set;
    end
  end

  // array and return data are not reset; the valid bits above qualify them
  always_ff @(posedge clk) begin
    if (accept && wr) mem[idx] <= data_in;
    if (accept && rd) rd_d1 <= mem[idx];
    rd_d2 <= rd_d1;
  end

endmodule

// File: tb/tb_four_bank_mem.sv
// tb/tb_four_bank_mem.sv - scoreboard bench for four_bank_mem against a cycle-level reference model.
module tb_four_bank_mem;
  localparam int MEM_WORDS = 8192;
  localparam int BANK_LAT  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = 16'h0, data_in = 16'h0;
  logic        wr = 1'b0, rd = 1'b0;
  logic [15:0] data_out;
  logic [3:0]  busy;
  logic        stall, err;

  four_bank_mem #(.MEM_WORDS(MEM_WORDS), .BANK_LAT(BANK_LAT)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
    .data_out(data_out), .busy(busy), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [3:0] busy; logic stall; logic err; } st_t;
  typedef struct { int due; logic [15:0] data; } rd_t;

  st_t         stq[$];
  rd_t         rq[$];
  logic [15:0] mem_model [int];
  int          free_at [4];
  logic        err_m = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One bus cycle: drive the request and predict what the memory must show this cycle.
  task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    int   b, word;
    logic mis, eset, acc;
    st_t  st;
    rd_t  rr;
    @(posedge clk); #1;
    cyc++;
    rd = r; wr = w; addr = a; data_in = d;
    b = int'(a[2:1]);
    word = (int'(a) / 2) % MEM_WORDS;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (r ^ w) & a[0];
`else
    mis = 1'b0;
`endif
    eset = (r & w) | mis;
    st.cyc = cyc;
    for (int i = 0; i < 4; i++) st.busy[i] = (cyc < free_at[i]);
    st.stall = (r ^ w) & st.busy[b] & ~mis;
    st.err = err_m;
    acc = (r ^ w) & ~st.busy[b] & ~eset;
    if (acc) begin
      free_at[b] = cyc + BANK_LAT;
      if (w) mem_model[word] = d;
      else begin
        rr.due = cyc + 2;
        rr.data = mem_model[word];
        rq.push_back(rr);
      end
    end
    err_m = err_m | eset;
    stq.push_back(st);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // Monitor: compares DUT outputs mid-cycle against the queued predictions.
  initial begin
    st_t         st;
    logic [15:0] exp_d;
    forever begin
      @(negedge clk);
      if (rst && stq.size() > 0) begin
        st = stq.pop_front();
        chk("busy", {12'h0, busy}, {12'h0, st.busy});
        chk("stall", {15'h0, stall}, {15'h0, st.stall});
        chk("err", {15'h0, err}, {15'h0, st.err});
        exp_d = 16'h0;
        if (rq.size() > 0 && rq[0].due == st.cyc) begin
          exp_d = rq[0].data;
          void'(rq.pop_front());
        end
        chk("data_out", data_out, exp_d);
      end
    end
  end

  initial begin
    logic [15:0] a;
    int          op;
    for (int i = 0; i < 4; i++) free_at[i] = 0;
    rd = 1'b1;
    #3;
    chk("reset_busy", {12'h0, busy}, 16'h0);
    chk("reset_stall", {15'h0, stall}, 16'h0);
    chk("reset_data", data_out, 16'h0);
    chk("reset_err", {15'h0, err}, 16'h0);
    rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // interleaved write burst, then back-to-back reads
    step(1'b0, 1'b1, 16'h0010, 16'h1111);
    step(1'b0, 1'b1, 16'h0012, 16'h2222);
    step(1'b0, 1'b1, 16'h0014, 16'h3333);
    step(1'b0, 1'b1, 16'h0016, 16'h4444);
    idle(6);
    step(1'b1, 1'b0, 16'h0010, 16'h0);
    step(1'b1, 1'b0, 16'h0012, 16'h0);
    step(1'b1, 1'b0, 16'h0014, 16'h0);
    step(1'b1, 1'b0, 16'h0016, 16'h0);
    idle(3);

    // fill the rest of a 32-word pool
    for (int i = 0; i < 32; i++) begin
      a = 16'(2 * i);
      if (a < 16'h0010 || a > 16'h0016) step(1'b0, 1'b1, a, 16'hA000 + 16'(i));
    end
    idle(4);

    // same-bank read held through the busy window
    step(1'b1, 1'b0, 16'h0010, 16'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0018, 16'h0);
    idle(4);

    // odd address: word access or alignment error depending on build
    step(1'b1, 1'b0, 16'h0011, 16'h0);
    idle(4);

    // randomized traffic, with address aliasing through bit 14
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      a = 16'($urandom_range(0, 63)) | (($urandom_range(0, 1) == 1) ? 16'h4000 : 16'h0);
      if (op < 4)      step(1'b1, 1'b0, a, 16'h0);
      else if (op < 7) step(1'b0, 1'b1, a, 16'($urandom_range(1, 65535)));
      else             idle(1);
    end
    idle(4);

    // rd & wr together: sticky err, no bank activity, word unchanged
    step(1'b1, 1'b1, 16'h0020, 16'h5555);
    idle(1);
    step(1'b1, 1'b0, 16'h0020, 16'h0);
    idle(4);
    chk("drain", 16'(rq.size()), 16'h0);

    // asynchronous reset with a read in flight
    step(1'b1, 1'b0, 16'h0012, 16'h0);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_busy", {12'h0, busy}, 16'h0);
    chk("async_data", data_out, 16'h0);
    chk("async_err", {15'h0, err}, 16'h0);
    rq.delete();
    stq.delete();
    for (int i = 0; i < 4; i++) free_at[i] = 0;
    err_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(5);
    step(1'b1, 1'b0, 16'h0014, 16'h0);
    idle(4);
    chk("final_drain", 16'(rq.size()), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
